// File: rtl/ili9341_spi_receiver_if.sv
// ILI9341 SPI receiver bus bundle.
// Carries the four raw SPI lines from the display controller and the decoded
// command / pixel outputs of the receiver.
//   master : drives spi_mosi/spi_sck/spi_cs/spi_dc, observes decoded outputs
//   slave  : samples the SPI lines, drives cmd_*, pixel_*, frame_done
interface ili9341_spi_receiver_if #(
  parameter int PIXEL_SIZE = 16
);
  logic                  spi_mosi;
  logic                  spi_sck;
  logic                  spi_cs;
  logic                  spi_dc;
  logic                  cmd_valid;
  logic [7:0]            cmd_byte;
  logic                  pixel_valid;
  logic [PIXEL_SIZE-1:0] pixel_data;
  logic [15:0]           pixel_x;
  logic [15:0]           pixel_y;
  logic                  frame_done;

  modport master (
    output spi_mosi, spi_sck, spi_cs, spi_dc,
    input  cmd_valid, cmd_byte, pixel_valid, pixel_data, pixel_x, pixel_y, frame_done
  );

  modport slave (
    input  spi_mosi, spi_sck, spi_cs, spi_dc,
    output cmd_valid, cmd_byte, pixel_valid, pixel_data, pixel_x, pixel_y, frame_done
  );
endinterface

// File: rtl/ili9341_spi_receiver.sv
// ILI9341 4-wire SPI receive-side decoder.
// Oversamples the SPI lines in the clk domain, assembles bytes, tracks the
// CASET/PASET address window and emits one strobed RGB565 pixel with its
// (x, y) coordinate for every pixel written after RAMWR.
// Ports:
//   clk, rst : system clock (>= 4x spi_sck), synchronous active-high reset
//   bus      : slave side of ili9341_spi_receiver_if (SPI in, decoded out)
module ili9341_spi_receiver #(
  parameter int WIDTH      = 240,
  parameter int HEIGHT     = 320,
  parameter int PIXEL_SIZE = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  ili9341_spi_receiver_if.slave         bus
);

  localparam logic [15:0] EC_RST = 16'(WIDTH - 1);
  localparam logic [15:0] EP_RST = 16'(HEIGHT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CASET, ST_PASET, ST_RAMWR, ST_OTHER
  } state_t;

  state_t state, state_nxt;

  logic [1:0] sck_sync, cs_sync, dc_sync, mosi_sync;
  logic       sck_prev;
  logic       sck_rise;

  logic [2:0] bit_cnt;
  logic [7:0] shift_p0;
  logic       byte_dc_p0;
  logic       vld_p0;

  logic [15:0] sc, ec, sp, ep;
  logic [15:0] cur_x, cur_y;
  logic [2:0]  param_idx;
  logic        pend;
  logic [7:0]  hi_byte;

  logic                  cmd_valid_p1, pixel_valid_p1, frame_done_p1;
  logic [7:0]            cmd_byte_p1;
  logic [PIXEL_SIZE-1:0] pixel_data_p1;
  logic [15:0]           pixel_x_p1, pixel_y_p1;

  // ---- input synchronizers and SCK edge detect ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      dc_sync   <= 2'b00;
      mosi_sync <= 2'b00;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], bus.spi_sck};
      cs_sync   <= {cs_sync[0], bus.spi_cs};
      dc_sync   <= {dc_sync[0], bus.spi_dc};
      mosi_sync <= {mosi_sync[0], bus.spi_mosi};
      sck_prev  <= sck_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_prev;

  // ---- stage p0: bit assembly ----
  // CS high wins over a coincident SCK edge, so a partial byte is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 3'd0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      if (cs_sync[1]) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) vld_p0 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!cs_sync[1] && sck_rise) begin
      shift_p0 <= {shift_p0[6:0], mosi_sync[1]};
      if (bit_cnt == 3'd7) byte_dc_p0 <= dc_sync[1];
    end
  end

  // ---- command FSM: next state ----
  always_comb begin
    state_nxt = state;
    if (vld_p0 && !byte_dc_p0) begin
      case (shift_p0)
        8'h2A:   state_nxt = ST_CASET;
        8'h2B:   state_nxt = ST_PASET;
        8'h2C:   state_nxt = ST_RAMWR;
        default: state_nxt = ST_OTHER;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ---- stage p1: byte decode, window registers, pixel strobe ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_p1   <= 1'b0;
      pixel_valid_p1 <= 1'b0;
      frame_done_p1  <= 1'b0;
      cmd_byte_p1    <= 8'd0;
      pixel_data_p1  <= '0;
      pixel_x_p1     <= 16'd0;
      pixel_y_p1     <= 16'd0;
      sc             <= 16'd0;
      ec             <= EC_RST;
      sp             <= 16'd0;
      ep             <= EP_RST;
      cur_x          <= 16'd0;
      cur_y          <= 16'd0;
      param_idx      <= 3'd0;
      pend           <= 1'b0;
    end else begin
      cmd_valid_p1   <= 1'b0;
      pixel_valid_p1 <= 1'b0;
      frame_done_p1  <= 1'b0;
      if (vld_p0) begin
        if (!byte_dc_p0) begin
          cmd_valid_p1 <= 1'b1;
          cmd_byte_p1  <= shift_p0;
          param_idx    <= 3'd0;
          if (shift_p0 == 8'h2C) begin
            cur_x <= sc;
            cur_y <= sp;
            pend  <= 1'b0;
          end
        end else begin
          case (state)
            // param_idx[2] marks that all four window bytes have arrived
            ST_CASET, ST_PASET: begin
              if (!param_idx[2]) begin
                param_idx <= param_idx + 3'd1;
                case ({state == ST_PASET, param_idx[1:0]})
                  3'b000: sc[15:8] <= shift_p0;
                  3'b001: sc[7:0]  <= shift_p0;
                  3'b010: ec[15:8] <= shift_p0;
                  3'b011: ec[7:0]  <= shift_p0;
                  3'b100: sp[15:8] <= shift_p0;
                  3'b101: sp[7:0]  <= shift_p0;
                  3'b110: ep[15:8] <= shift_p0;
                  default: ep[7:0] <= shift_p0;
                endcase
              end
            end
            ST_RAMWR: begin
              if (!pend) begin
                hi_byte <= shift_p0;
                pend    <= 1'b1;
              end else begin
                pend           <= 1'b0;
                pixel_valid_p1 <= 1'b1;
                pixel_data_p1  <= {hi_byte, shift_p0};
                pixel_x_p1     <= cur_x;
                pixel_y_p1     <= cur_y;
                // Equality-only compares: an inverted window wraps through 0xFFFF.
                if (cur_x != ec) begin
                  cur_x <= cur_x + 16'd1;
                end else if (cur_y != ep) begin
                  cur_x <= sc;
                  cur_y <= cur_y + 16'd1;
                end else begin
                  frame_done_p1 <= 1'b1;
                  cur_x         <= sc;
                  cur_y         <= sp;
                end
              end
            end
            default: ;
          endcase
        end
      end else if (cs_sync[1]) begin
        pend <= 1'b0;
      end
    end
  end

  assign bus.cmd_valid   = cmd_valid_p1;
  assign bus.cmd_byte    = cmd_byte_p1;
  assign bus.pixel_valid = pixel_valid_p1;
  assign bus.pixel_data  = pixel_data_p1;
  assign bus.pixel_x     = pixel_x_p1;
  assign bus.pixel_y     = pixel_y_p1;
  assign bus.frame_done  = frame_done_p1;

endmodule
